// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_D  = 1'b0,
    OWN_IF = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_stats.sv
// Free-running grant and stall counters for the memory port arbiter.
module mem_arb_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_grant_i,
  input  logic        d_grant_i,
  input  logic        stall_i,
  output logic [31:0] if_grants_o,
  output logic [31:0] d_grants_o,
  output logic [31:0] stall_cycles_o
);

  logic [31:0] if_grants_q, d_grants_q, stall_cycles_q;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_grants_q    <= '0;
      d_grants_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (if_grant_i) if_grants_q    <= if_grants_q + 32'd1;
      if (d_grant_i)  d_grants_q     <= d_grants_q + 32'd1;
      if (stall_i)    stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign if_grants_o    = if_grants_q;
  assign d_grants_o     = d_grants_q;
  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one multi-cycle memory port.
// Define MEM_ARB_STATS_EN to add the stat_* grant/stall counter outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = 2,
  parameter int MEM_DEPTH    = 31,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_we,
  output logic              if_ack,
  output logic              d_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              if_stall,
  output logic              d_stall,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_if_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_stall_cycles
`endif
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(MEM_DEPTH);

  // Handshake: a requester raises req with stable address/data and holds it
  // until its ack pulses for one cycle; it must drop or change req the cycle
  // after. Stall is req && !ack, so the pipeline is frozen until that pulse.

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              oor_q, oor_d;
  logic              wren_q, wren_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_if, grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      oor_q      <= 1'b0;
      wren_q     <= 1'b0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      oor_q      <= oor_d;
      wren_q     <= wren_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    oor_d      = oor_q;
    wren_d     = 1'b0;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_if   = 1'b0;
    grant_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // Data has priority unless fetch has been passed over STARVE_LIMIT times.
          if (if_req && (!d_req || starve_q == STARVE_MAX)) grant_if = 1'b1;
          else                                              grant_d  = 1'b1;
          state_d = ACCESS;
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
          if (grant_if) begin
            owner_d  = OWN_IF;
            addr_d   = if_addr;
            we_d     = 1'b0;
            oor_d    = (if_addr >= DEPTH_A);
            starve_d = '0;
          end else begin
            owner_d = OWN_D;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
            oor_d   = (d_addr >= DEPTH_A);
            wren_d  = d_we && (d_addr < DEPTH_A);
            if (if_req && starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_IF)  if_rdata_d = oor_q ? '0 : mem_rdata;
          else if (!we_q)         d_rdata_d  = oor_q ? '0 : mem_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign if_ack     = (state_q == RESP) && (owner_q == OWN_IF);
  assign d_ack      = (state_q == RESP) && (owner_q == OWN_D);
  assign d_err      = d_ack && oor_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign if_stall   = if_req && !if_ack;
  assign d_stall    = d_req && !d_ack;
  assign mem_select = (owner_q == OWN_IF);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wren   = wren_q;
  assign dbg_state  = state_q;

`ifdef MEM_ARB_STATS_EN
  mem_arb_stats u_stats (
    .clk            (clk),
    .rst            (reset),
    .if_grant_i     (grant_if),
    .d_grant_i      (grant_d),
    .stall_i        (if_stall || d_stall),
    .if_grants_o    (stat_if_grants),
    .d_grants_o     (stat_d_grants),
    .stall_cycles_o (stat_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus arbitration,
// starvation and mid-access reset sequences against a small memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [29:0] if_addr, d_addr;
  logic [31:0] d_wdata;
  logic        if_ack, d_ack, d_err, if_stall, d_stall;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_select, mem_wren;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_if_grants, stat_d_grants, stat_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MEM_LATENCY(2), .MEM_DEPTH(31), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .if_ack(if_ack), .d_ack(d_ack), .if_rdata(if_rdata), .d_rdata(d_rdata),
    .d_err(d_err), .if_stall(if_stall), .d_stall(d_stall),
    .mem_select(mem_select), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
`ifdef MEM_ARB_STATS_EN
    , .stat_if_grants(stat_if_grants), .stat_d_grants(stat_d_grants),
    .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Memory model: unwritten word a reads 0x1000_0000 + a, except word 7 reads 5.
  logic [31:0] mem_wr [0:63];
  logic [63:0] mem_valid = '0;

  function automatic logic [31:0] mem_default(input logic [5:0] a);
    if (a == 6'd7) return 32'h0000_0005;
    return 32'h1000_0000 + {26'd0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_wren) begin
      mem_wr[mem_addr[5:0]]    <= mem_wdata;
      mem_valid[mem_addr[5:0]] <= 1'b1;
    end
  end

  always_comb begin
    mem_rdata = mem_valid[mem_addr[5:0]] ? mem_wr[mem_addr[5:0]] : mem_default(mem_addr[5:0]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fetch;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_wren;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  vec_t vecs [12];

  // Driver: one isolated transaction, measured from the cycle req is raised.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0, wren_n = 0, other = 0;
    logic got = 1'b0, err_seen = 1'b0;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    if (v.fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      d_req = 1'b1; d_addr = v.addr; d_we = v.we; d_wdata = v.wdata;
    end
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mem_wren) begin
        wren_n++;
        check({tag, "_wren_addr"}, {2'b0, mem_addr}, {2'b0, v.addr});
        check({tag, "_wren_sel"}, {31'd0, mem_select}, 32'd0);
        check({tag, "_wren_data"}, mem_wdata, v.wdata);
      end
      if (v.fetch ? d_ack : if_ack) other++;
      if (v.fetch ? if_ack : d_ack) begin
        got = 1'b1;
        err_seen = d_err;
      end
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    check({tag, "_latency"}, got ? cyc : 99, 32'd3);
    check({tag, "_err"}, {31'd0, err_seen}, {31'd0, v.exp_err});
    check({tag, "_wren_cycles"}, wren_n, v.exp_wren);
    check({tag, "_other_ack"}, other, 32'd0);
    check({tag, "_if_rdata"}, if_rdata, v.exp_if_rdata);
    check({tag, "_d_rdata"}, d_rdata, v.exp_d_rdata);
    @(negedge clk);
    check({tag, "_ack_pulse"}, {30'd0, if_ack, d_ack}, 32'd0);
  endtask

  initial begin
    int cyc, d_before_if, if_cyc, d_after_cyc, stall_bad, d_cyc, acks;
    logic seen_if;

    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;

    //             fetch we    addr   wdata          err  wren  if_rdata        d_rdata
    vecs[0]  = '{1'b0, 1'b0, 30'd7,  32'h0,         1'b0, 0, 32'h0,         32'h0000_0005};
    vecs[1]  = '{1'b0, 1'b1, 30'd16, 32'hDEAD_BEEF, 1'b0, 1, 32'h0,         32'h0000_0005};
    vecs[2]  = '{1'b0, 1'b0, 30'd16, 32'h0,         1'b0, 0, 32'h0,         32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 1'b0, 30'd3,  32'h0,         1'b0, 0, 32'h1000_0003, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 1'b0, 30'd40, 32'h0,         1'b1, 0, 32'h1000_0003, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 30'd40, 32'h0000_1234, 1'b1, 0, 32'h1000_0003, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 30'd35, 32'h0,         1'b0, 0, 32'h0,         32'h0};
    vecs[7]  = '{1'b0, 1'b0, 30'd30, 32'h0,         1'b0, 0, 32'h0,         32'h1000_001E};
    vecs[8]  = '{1'b0, 1'b0, 30'd31, 32'h0,         1'b1, 0, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, 1'b0, 30'd30, 32'h0,         1'b0, 0, 32'h1000_001E, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 30'd0,  32'hCAFE_F00D, 1'b0, 1, 32'h1000_001E, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 30'd0,  32'h0,         1'b0, 0, 32'hCAFE_F00D, 32'h0};

    repeat (3) @(negedge clk);
    check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    check("rst_wren", {31'd0, mem_wren}, 32'd0);
    check("rst_select", {31'd0, mem_select}, 32'd1);
    check("rst_addr", {2'b0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", if_rdata | d_rdata, 32'd0);
    check("rst_err", {31'd0, d_err}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Simultaneous requests: data first, fetch four cycles later.
    @(negedge clk);
    if_req = 1'b1; if_addr = 30'd5;
    d_req = 1'b1; d_addr = 30'd7; d_we = 1'b0;
    cyc = 0; d_cyc = 99; if_cyc = 99; stall_bad = 0;
    while (if_cyc == 99 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (d_ack) begin d_cyc = cyc; d_req = 1'b0; end
      if (if_ack) if_cyc = cyc;
      else if (!if_stall) stall_bad++;
    end
    if_req = 1'b0;
    check("sim_d_ack_cycle", d_cyc, 32'd3);
    check("sim_if_ack_cycle", if_cyc, 32'd7);
    check("sim_if_stall", stall_bad, 32'd0);
    check("sim_if_rdata", if_rdata, 32'h1000_0005);
    check("sim_d_rdata", d_rdata, 32'h0000_0005);

    // Starvation: fetch forced after four data grants while it waits.
    @(negedge clk);
    if_req = 1'b1; if_addr = 30'd2;
    d_req = 1'b1; d_addr = 30'd8; d_we = 1'b0;
    cyc = 0; d_before_if = 0; if_cyc = 99; d_after_cyc = 99; seen_if = 1'b0;
    while (d_after_cyc == 99 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (if_ack) begin if_cyc = cyc; seen_if = 1'b1; if_req = 1'b0; end
      if (d_ack) begin
        if (seen_if) d_after_cyc = cyc;
        else         d_before_if++;
        d_addr = d_addr + 30'd1;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("starve_d_acks_first", d_before_if, 32'd4);
    check("starve_if_ack_cycle", if_cyc, 32'd19);
    check("starve_next_d_cycle", d_after_cyc, 32'd23);
    check("starve_if_rdata", if_rdata, 32'h1000_0002);

    // Reset during the write cycle of a store.
    repeat (2) @(negedge clk);
    d_req = 1'b1; d_addr = 30'd20; d_we = 1'b1; d_wdata = 32'h0000_55AA;
    cyc = 0;
    while (!mem_wren && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("rstmid_wren_seen", {31'd0, mem_wren}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rstmid_wren_drop", {31'd0, mem_wren}, 32'd0);
    check("rstmid_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_ack || d_ack) acks++;
    end
    check("rstmid_no_ack", acks, 32'd0);
    check("rstmid_idle", {30'd0, dbg_state}, 32'd0);
    check("rstmid_mem_untouched", mem_valid[20] ? mem_wr[20] : mem_default(6'd20), 32'h1000_0014);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
